ring_exchange_unit: RTL and testbench
=====================================

Name: ring_exchange_unit

Overview:
- Bank of DEPTH registers that is filled word by word, then permuted a programmed number of clock cycles, then drained word by word.
- Permutation is one of three: rotate left, rotate right, or pairwise swap of adjacent slots.
- Every exchange updates all slots at once from the previous-cycle values, so no slot reads a value written in the same cycle.
- Sits between a stream source and a stream sink. It is the register-exchange stage that feeds downstream consumers, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of register slots (>=2).
- CNT_W, 8, width of the exchange-count field.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  unit accepts a word this cycle.
- start  input  1  begin exchange phase; sampled in ARMED only.
- mode  input  2  00 rotate left, 01 rotate right, 10 pair swap, 11 hold (no change per step); sampled with start.
- count  input  CNT_W  number of exchange steps; sampled with start.
- busy  output  1  high in EXCHANGE.
- done  output  1  one-cycle pulse on entry to DRAIN.
- out_valid  output  1  downstream word valid.
- out_data  output  WIDTH  downstream word.
- out_ready  input  1  downstream accepts word.

Behaviour:
- Reset (async, any state): state=FILL; all slots, write index, read index and step counter cleared to 0.
- Reset outputs: in_ready=0 during rst, then 1 in FILL; busy=0, done=0, out_valid=0, out_data=0.
- FILL:
  - in_ready=1.
  - A word is accepted when in_valid&in_ready at posedge. It is written to slot[wr_idx] and wr_idx increments; slot 0 is filled first.
  - After slot DEPTH-1 is accepted, the next state is ARMED.
- ARMED:
  - in_ready=0; start is honoured only here and is ignored in all other states.
  - On start: latch mode and count. If count==0, go to DRAIN next cycle (done pulses). Otherwise go to EXCHANGE with step counter = count.
- EXCHANGE:
  - busy=1. Each cycle applies one step to all slots simultaneously, using pre-edge values.
  - Left: new[i] = old[(i+1) mod DEPTH].
  - Right: new[i] = old[(i-1) mod DEPTH].
  - Swap: new[2k] = old[2k+1] and new[2k+1] = old[2k]. If DEPTH is odd, the last slot holds.
  - Hold: no change.
  - The step counter decrements per step. The step applied when the counter reaches 1 is the last, and the next state is DRAIN.
  - Exchange latency is exactly count cycles. Start to first out_valid is count+1 cycles (1 cycle when count==0).
- DRAIN:
  - done=1 in the first DRAIN cycle only.
  - out_valid=1 and out_data=slot[rd_idx] (registered), starting at slot 0.
  - On out_valid&out_ready, rd_idx increments. out_data must stay stable while out_ready=0.
  - After slot DEPTH-1 is accepted, clear the indices and return to FILL; in_ready=1 in the following cycle.
- No input and output overlap: in_ready and out_valid are never both 1.
- in_valid outside FILL is ignored (no write).
- Counter arithmetic: unsigned CNT_W. count=2^CNT_W-1 must complete without wrap.
- Reset asserted mid-EXCHANGE or mid-DRAIN discards all data. After release, the unit is in FILL with no spurious out_valid or done.

Test Plan:
- DEPTH=4, load 0A,0B,0C,0D; start mode=00 count=1 -> busy 1 cycle, done pulse, drain 0B,0C,0D,0A.
- Same load, mode=01 count=2 -> busy 2 cycles, drain 0C,0D,0A,0B. Then mode=00 count=4 on a fresh load -> drain 0A,0B,0C,0D.
- Same load, mode=10 count=1 -> drain 0B,0A,0D,0C; count=2 -> drain 0A,0B,0C,0D; count=0 -> done one cycle after start, busy never high, original order.
- Backpressure: hold out_ready=0 for 3 cycles mid-drain -> out_data/out_valid stable, no word lost or duplicated. Toggle in_valid with gaps in FILL -> only valid beats stored; start pulsed during FILL/EXCHANGE/DRAIN is ignored.
- Async reset: assert rst mid-EXCHANGE (count=5, after step 2) -> busy/out_valid/done go 0 immediately. After release in_ready=1 and a new load of 01,02,03,04 with count=0 drains 01,02,03,04.
- Stress: count=255 mode=00 on DEPTH=4 -> 255 busy cycles, drain equals a rotate-left by 3 (0D,0A,0B,0C).

Source files
------------

// File: rtl/ring_exchange_unit.sv
`default_nettype none
// ============================================================================
// ring_exchange_unit: fill a bank of slots, permute them N steps, then drain.
// Revision: 1.0
// ============================================================================
module ring_exchange_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_FILL     = 2'd0,
    S_ARMED    = 2'd1,
    S_EXCHANGE = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_d [DEPTH];
  logic [WIDTH-1:0] rot_l  [DEPTH];
  logic [WIDTH-1:0] rot_r  [DEPTH];
  logic [WIDTH-1:0] swp    [DEPTH];
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // All three permutations read only pre-edge slot values.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_perm
    assign rot_l[gi] = slot_q[(gi + 1) % DEPTH];
    assign rot_r[gi] = slot_q[(gi + DEPTH - 1) % DEPTH];
    if (gi % 2 == 1) begin : g_odd
      assign swp[gi] = slot_q[gi - 1];
    end else if (gi + 1 < DEPTH) begin : g_even
      assign swp[gi] = slot_q[gi + 1];
    end else begin : g_last
      assign swp[gi] = slot_q[gi];
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          slot_d[wr_idx_q] = in_data;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            state_d  = S_ARMED;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      S_ARMED: begin
        if (start) begin
          mode_d  = mode;
          cnt_d   = count;
          state_d = (count == '0) ? S_DRAIN : S_EXCHANGE;
        end
      end
      S_EXCHANGE: begin
        case (mode_q)
          2'b00:   slot_d = rot_l;
          2'b01:   slot_d = rot_r;
          2'b10:   slot_d = swp;
          default: slot_d = slot_q;
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            state_d  = S_FILL;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_FILL;
    endcase

    // Outputs are computed from next-state values so they register cleanly.
    busy_d      = (state_d == S_EXCHANGE);
    out_valid_d = (state_d == S_DRAIN);
    done_d      = (state_d == S_DRAIN) && (state_q != S_DRAIN);
    out_data_d  = (state_d == S_DRAIN) ? slot_d[rd_idx_d] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == S_FILL) && !rst;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_exchange_unit.sv
`default_nettype none
// ============================================================================
// tb_ring_exchange_unit: directed scoreboard bench for ring_exchange_unit.
// Revision: 1.0
// ============================================================================
module tb_ring_exchange_unit;

  typedef logic [7:0] word_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  word_t      in_data;
  logic       in_ready;
  logic       start;
  logic [1:0] mode;
  word_t      count;
  logic       busy;
  logic       done;
  logic       out_valid;
  word_t      out_data;
  logic       out_ready;

  int    checks = 0;
  int    errors = 0;
  word_t sb [$];
  word_t mdl [4];

  ring_exchange_unit #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .start     (start),
    .mode      (mode),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic [1:0] m, input int c);
    word_t t [4];
    for (int s = 0; s < c; s++) begin
      for (int i = 0; i < 4; i++) begin
        case (m)
          2'b00:   t[i] = mdl[(i + 1) % 4];
          2'b01:   t[i] = mdl[(i + 3) % 4];
          2'b10:   t[i] = mdl[i ^ 1];
          default: t[i] = mdl[i];
        endcase
      end
      mdl = t;
    end
  endtask

  task automatic load4(input word_t a, input word_t b, input word_t c, input word_t d,
                       input bit gaps);
    word_t w [4];
    w = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0; in_data = 8'hFF; start = 1'b1; mode = 2'b11; count = 8'd0;
        tick;
        start = 1'b0;
      end
      chk("fill_ready", in_ready, 1);
      in_valid = 1'b1; in_data = w[i];
      tick;
    end
    in_valid = 1'b0;
    if (gaps) begin
      in_valid = 1'b1; in_data = 8'hEE;
      tick;
      in_valid = 1'b0;
    end
    chk("armed_ready", in_ready, 0);
    mdl = w;
  endtask

  task automatic exch(input logic [1:0] m, input word_t c, input bit poke);
    int n;
    mode = m; count = c; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      chk("busy_no_valid", out_valid, 0);
      if (poke && n == 0) begin
        start = 1'b1; mode = 2'b10; count = 8'd9;
      end
      n++;
      tick;
      start = 1'b0;
    end
    chk("busy_cycles", n, c);
    chk("done_entry", done, 1);
    chk("first_valid", out_valid, 1);
    model_apply(m, int'(c));
    for (int i = 0; i < 4; i++) sb.push_back(mdl[i]);
  endtask

  task automatic drain(input int stall_beat);
    int    n;
    word_t exp;
    word_t held;
    n = sb.size();
    out_ready = 1'b1;
    for (int b = 0; b < n; b++) begin
      exp = sb.pop_front();
      chk("drain_valid", out_valid, 1);
      chk("no_overlap", in_ready & out_valid, 0);
      if (b > 0) chk("done_once", done, 0);
      if (b == stall_beat) begin
        out_ready = 1'b0; start = 1'b1; mode = 2'b01; count = 8'd3;
        held = out_data;
        for (int s = 0; s < 3; s++) begin
          tick;
          start = 1'b0;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, held);
        end
        out_ready = 1'b1;
      end
      chk("drain_data", out_data, exp);
      tick;
    end
    chk("drain_end_valid", out_valid, 0);
    chk("refill_ready", in_ready, 1);
    chk("drain_end_done", done, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0;
    mode = 2'b00; count = '0; out_ready = 1'b1;
    repeat (3) tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    load4(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0); exch(2'b00, 8'd1, 1'b0); drain(-1);
    load4(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0); exch(2'b01, 8'd2, 1'b0); drain(-1);
    load4(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0); exch(2'b00, 8'd4, 1'b0); drain(-1);
    load4(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0); exch(2'b10, 8'd1, 1'b0); drain(-1);
    load4(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0); exch(2'b10, 8'd2, 1'b0); drain(-1);
    load4(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0); exch(2'b10, 8'd0, 1'b0); drain(-1);
    load4(8'h11, 8'h22, 8'h33, 8'h44, 1'b0); exch(2'b11, 8'd3, 1'b0); drain(-1);

    // Gapped fill, ignored starts, stray in_valid in ARMED, mid-drain stall.
    load4(8'h51, 8'h62, 8'h73, 8'h84, 1'b1); exch(2'b01, 8'd3, 1'b1); drain(1);

    // Async reset in the middle of an exchange.
    load4(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0);
    mode = 2'b00; count = 8'd5; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_done", done, 0);
    chk("arst_in_ready", in_ready, 0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    load4(8'h01, 8'h02, 8'h03, 8'h04, 1'b0); exch(2'b00, 8'd0, 1'b0); drain(-1);

    load4(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0); exch(2'b00, 8'd255, 1'b0); drain(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
